// File: rtl/decode_stage_pkg.sv
// ============================================================================
// decode_stage_pkg : shared RV32I opcode, immediate-extender and record types
// Rev 1.0
// ============================================================================
`default_nettype none

package decode_stage_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Select codes shared with the immediate extender.
  typedef enum logic [2:0] {
    IMM_SEXT12 = 3'b000,
    IMM_SEXT13 = 3'b001,
    IMM_SEXT20 = 3'b010,
    IMM_ZEXT12 = 3'b101
  } imm_func_e;

  typedef enum logic [1:0] {
    SHL_NONE = 2'b00,
    SHL_1    = 2'b01,
    SHL_12   = 2'b10
  } imm_shl_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [19:0] imm_raw;
    imm_func_e   imm_func;
    imm_shl_e    imm_shl;
    logic        illegal;
  } dec_instr_t;

endpackage

`default_nettype wire

// File: rtl/decode_stage_if.sv
// ============================================================================
// decode_stage_if : fetch-side and execute-side handshake bundle of decode
// Rev 1.0
// ============================================================================
`default_nettype none

interface decode_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [19:0] out_imm_raw;
  logic [2:0]  out_imm_func;
  logic [1:0]  out_imm_shl;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_funct3, out_imm_raw, out_imm_func, out_imm_shl, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_funct3, out_imm_raw, out_imm_func, out_imm_shl, out_illegal
  );

endinterface

`default_nettype wire

// File: rtl/decode_stage_instr_field_decode.sv
// ============================================================================
// instr_field_decode : combinational RV32I field and immediate-layout extraction
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_field_decode
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output dec_instr_t  dec
);

  always_comb begin
    dec          = '0;
    dec.pc       = pc;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.funct3   = instr[14:12];
    dec.imm_func = IMM_SEXT12;
    dec.imm_shl  = SHL_NONE;

    if (instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      unique case (instr[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          dec.imm_raw = {8'b0, instr[31:20]};
        end
        OPC_STORE: begin
          dec.imm_raw = {8'b0, instr[31:25], instr[11:7]};
        end
        // Branch offset is packed with its implicit zero LSB already in place.
        OPC_BRANCH: begin
          dec.imm_raw  = {7'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          dec.imm_func = IMM_SEXT13;
        end
        OPC_LUI, OPC_AUIPC: begin
          dec.imm_raw  = instr[31:12];
          dec.imm_func = IMM_SEXT20;
          dec.imm_shl  = SHL_12;
        end
        // JAL offset omits its zero LSB; the extender restores it with a <<1.
        OPC_JAL: begin
          dec.imm_raw  = {instr[31], instr[19:12], instr[20], instr[30:21]};
          dec.imm_func = IMM_SEXT20;
          dec.imm_shl  = SHL_1;
        end
        OPC_SYSTEM: begin
          dec.imm_raw  = {8'b0, instr[31:20]};
          dec.imm_func = IMM_ZEXT12;
        end
        OPC_OP: begin
          dec.imm_raw = '0;
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : RV32I decode with a two-entry skid buffer (head + skid)
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  decode_stage_if.slave bus
);

  dec_instr_t dec_in;

  logic       head_valid_q, head_valid_d;
  logic       skid_valid_q, skid_valid_d;
  dec_instr_t head_q, head_d;
  dec_instr_t skid_q, skid_d;
  logic       in_ready_q, in_ready_d;

  logic       in_xfer;
  logic       out_xfer;

  instr_field_decode u_instr_field_decode (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .dec   (dec_in)
  );

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = head_valid_q && bus.out_ready;

  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    head_d       = head_q;
    skid_d       = skid_q;

    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_xfer) begin
      // Head drains: skid (if any) advances and new input fills the freed slot.
      if (skid_valid_q) begin
        head_d       = skid_q;
        skid_valid_d = in_xfer;
        if (in_xfer) begin
          skid_d = dec_in;
        end
      end else begin
        head_valid_d = in_xfer;
        if (in_xfer) begin
          head_d = dec_in;
        end
      end
    end else if (in_xfer) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_d       = dec_in;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = dec_in;
      end
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = head_valid_q;
  assign bus.out_pc       = head_q.pc;
  assign bus.out_rd       = head_q.rd;
  assign bus.out_rs1      = head_q.rs1;
  assign bus.out_rs2      = head_q.rs2;
  assign bus.out_funct3   = head_q.funct3;
  assign bus.out_imm_raw  = head_q.imm_raw;
  assign bus.out_imm_func = head_q.imm_func;
  assign bus.out_imm_shl  = head_q.imm_shl;
  assign bus.out_illegal  = head_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage : directed and randomized checks of decode_stage vs a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [19:0] imm;
    logic [2:0]  func;
    logic [1:0]  shl;
    logic        ill;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  rec_t q[$];
  bit   m_ready  = 1'b0;

  function automatic rec_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    rec_t r;
    r     = '0;
    r.pc  = pc;
    r.rd  = i[11:7];
    r.rs1 = i[19:15];
    r.rs2 = i[24:20];
    r.f3  = i[14:12];
    if (i[1:0] != 2'b11) r.ill = 1'b1;
    else begin
      case (i[6:0])
        7'h13, 7'h03, 7'h67: r.imm = {8'h0, i[31:20]};
        7'h23: r.imm = {8'h0, i[31:25], i[11:7]};
        7'h63: begin r.imm = {7'h0, i[31], i[7], i[30:25], i[11:8], 1'b0}; r.func = 3'b001; end
        7'h37, 7'h17: begin r.imm = i[31:12]; r.func = 3'b010; r.shl = 2'b10; end
        7'h6F: begin r.imm = {i[31], i[19:12], i[20], i[30:21]}; r.func = 3'b010; r.shl = 2'b01; end
        7'h73: begin r.imm = {8'h0, i[31:20]}; r.func = 3'b101; end
        7'h33: r.imm = '0;
        default: r.ill = 1'b1;
      endcase
    end
    return r;
  endfunction

  function automatic rec_t observe();
    rec_t r;
    r.pc   = bus.out_pc;
    r.rd   = bus.out_rd;
    r.rs1  = bus.out_rs1;
    r.rs2  = bus.out_rs2;
    r.f3   = bus.out_funct3;
    r.imm  = bus.out_imm_raw;
    r.func = bus.out_imm_func;
    r.shl  = bus.out_imm_shl;
    r.ill  = bus.out_illegal;
    return r;
  endfunction

  task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // Advance one clock edge and apply the same edge to the queue model.
  task automatic tick();
    bit in_x;
    bit out_x;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ready = 1'b0;
    end else if (flush) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      in_x  = bus.in_valid && m_ready;
      out_x = (q.size() > 0) && bus.out_ready;
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(ref_decode(bus.in_instr, bus.in_pc));
      m_ready = (q.size() < 2);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (observe() !== rec_t'(0)) begin failures++; $display("FAIL reset_data got=%h exp=0", observe()); end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early got=%b exp=0", bus.in_ready); end
    tick();
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_vectors();
    logic [31:0] vi  [4] = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h0000007F};
    logic [19:0] vim [4] = '{20'h00FFF, 20'h01FFC, 20'h12345, 20'h00000};
    logic [2:0]  vf  [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
    logic [1:0]  vs  [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
    logic        vil [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0]  vrd [4] = '{5'd1, 5'd29, 5'd5, 5'd0};
    for (int k = 0; k < 4; k++) begin
      drive(1, vi[k], 32'h1000 + 32'(k * 4), 1, 0);
      tick();
      drive(0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_valid got=%b exp=1", k, bus.out_valid); end
      checks++;
      if ({bus.out_imm_raw, bus.out_imm_func, bus.out_imm_shl, bus.out_illegal, bus.out_rd} !==
          {vim[k], vf[k], vs[k], vil[k], vrd[k]}) begin
        failures++;
        $display("FAIL vec%0d_fields got imm=%h func=%b shl=%b ill=%b rd=%0d exp imm=%h func=%b shl=%b ill=%b rd=%0d",
                 k, bus.out_imm_raw, bus.out_imm_func, bus.out_imm_shl, bus.out_illegal, bus.out_rd,
                 vim[k], vf[k], vs[k], vil[k], vrd[k]);
      end
      if (k == 0) begin
        checks++; if (bus.out_rs1 !== 5'd0) begin failures++; $display("FAIL vec0_rs1 got=%0d exp=0", bus.out_rs1); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia = 32'h00500113, ib = 32'h00A00193, ic = 32'h00F00213;
    logic [31:0] pa = 32'h200, pb = 32'h204, pc = 32'h208;
    drive(1, ia, pa, 0, 0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_a got=%b exp=1", bus.in_ready); end
    tick();
    drive(1, ib, pb, 0, 0);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.out_pc} !== {1'b1, pa}) begin failures++; $display("FAIL bp_head_a got=%b/%h exp=1/%h", bus.out_valid, bus.out_pc, pa); end
    tick();
    drive(1, ic, pc, 0, 0);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", bus.in_ready); end
      checks++; if (observe() !== ref_decode(ia, pa)) begin failures++; $display("FAIL bp_frozen got=%h exp=%h", observe(), ref_decode(ia, pa)); end
      tick();
    end
    drive(1, ic, pc, 1, 0);
    @(negedge clk);
    checks++; if (bus.out_pc !== pa) begin failures++; $display("FAIL bp_out_first got=%h exp=%h", bus.out_pc, pa); end
    tick();
    @(negedge clk);
    checks++; if ({bus.out_pc, bus.in_ready} !== {pb, 1'b1}) begin failures++; $display("FAIL bp_out_second got=%h/%b exp=%h/1", bus.out_pc, bus.in_ready, pb); end
    tick();
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.out_pc} !== {1'b1, pc}) begin failures++; $display("FAIL bp_out_third got=%b/%h exp=1/%h", bus.out_valid, bus.out_pc, pc); end
    tick();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    drive(1, 32'h00100093, 32'h300, 0, 0); tick();
    drive(1, 32'h00200093, 32'h304, 0, 0); tick();
    drive(1, 32'h00300093, 32'h308, 0, 1);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_full got=%b exp=0", bus.in_ready); end
    tick();
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL flush_full got=%b%b exp=01", bus.out_valid, bus.in_ready); end
    tick();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%b exp=0", bus.out_valid); end
    // Flush while the input could have been accepted and the head is draining.
    drive(1, 32'h00400093, 32'h30C, 1, 0); tick();
    drive(1, 32'h00500093, 32'h310, 1, 1); tick();
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL flush_open got=%b%b exp=01", bus.out_valid, bus.in_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  opcs [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
    logic [31:0] r;
    logic [31:0] r2;
    logic [6:0]  opc;
    for (int n = 0; n < 500; n++) begin
      r  = $urandom;
      r2 = $urandom;
      opc = (r2[3:0] < 4'd12) ? opcs[r2[3:0] % 10] : r2[10:4];
      drive(($urandom_range(0, 9) < 7), {r[31:7], opc}, $urandom,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      @(negedge clk);
      checks++; if (bus.out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.out_valid, q.size() > 0); end
      checks++; if (bus.in_ready !== m_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.in_ready, m_ready); end
      if (q.size() > 0 && bus.out_valid === 1'b1) begin
        checks++; if (observe() !== q[0]) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, observe(), q[0]); end
      end
      tick();
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream();
    drive(1, 32'h00700093, 32'h400, 0, 0); tick();
    drive(1, 32'h00800093, 32'h404, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.out_valid, bus.in_ready} !== 2'b00) begin failures++; $display("FAIL mid_rst_async got=%b%b exp=00", bus.out_valid, bus.in_ready); end
    checks++; if (observe() !== rec_t'(0)) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", observe()); end
    q.delete();
    m_ready = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.in_ready} !== 2'b00) begin failures++; $display("FAIL mid_rel_early got=%b%b exp=00", bus.out_valid, bus.in_ready); end
    tick();
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL mid_rel got=%b%b exp=01", bus.out_valid, bus.in_ready); end
    drive(1, 32'h00900093, 32'h408, 1, 0); tick();
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h408}) begin failures++; $display("FAIL mid_resume got=%b/%h exp=1/408", bus.out_valid, bus.out_pc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
